ascon_seq_ctrl: RTL

Sequencing controller for the Ascon-AEAD128 datapath. It walks the state register and the permutation core through Initialization, Associated Data, Plaintext/Ciphertext and Finalization. It issues one state-update op code per step and one permutation request per round group, and it accepts 128-bit data blocks through a valid/ready handshake. It sits between the subsystem register interface and the 320-bit state/permutation datapath, and it holds no key, nonce or state data itself.

---
 rtl/ascon_seq_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ascon_seq_ctrl.sv
// ascon_seq_ctrl: sequencing controller for the Ascon-AEAD128 datapath.
// Walks Initialization -> Associated Data -> Plaintext/Ciphertext -> Finalization.
// One state-update op code is issued per step and one permutation request per
// round group. Data blocks are accepted through a valid/ready handshake.
// No key, nonce or state data is held here.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                begin an operation (sampled in IDLE only)
//   ad_en_i, decrypt_i     operation mode, latched together with start_i
//   blk_valid_i/_last_i    datapath block available / last block of its phase
//   blk_ready_o            block accepted this cycle (AD_WAIT, MSG_WAIT only)
//   op_valid_o, op_o       datapath applies op_o at this edge (op 8 = no-op)
//   perm_start_o           one-cycle permutation start pulse
//   perm_rounds_o          round count, valid while perm_start_o=1
//   perm_done_i            permutation finished pulse
//   busy_o, done_o         not idle / tag ready pulse
//
// Build option: ASCON_SEQ_DECRYPT_EN enables decryption (op 5). Without it the
// controller is encrypt-only and decrypt_i is ignored.
module ascon_seq_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       ad_en_i,
  input  logic       decrypt_i,
  input  logic       blk_valid_i,
  input  logic       blk_last_i,
  output logic       blk_ready_o,
  output logic       op_valid_o,
  output logic [3:0] op_o,
  output logic       perm_start_o,
  output logic [3:0] perm_rounds_o,
  input  logic       perm_done_i,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [3:0] {
    AsconOp0 = 4'd0, AsconOp1 = 4'd1, AsconOp2 = 4'd2, AsconOp3 = 4'd3,
    AsconOp4 = 4'd4, AsconOp5 = 4'd5, AsconOp6 = 4'd6, AsconOp7 = 4'd7,
    AsconOp8 = 4'd8
  } ascon_op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PSTART, S_PWAIT, S_KEYX,
    S_AD_WAIT, S_DOMSEP, S_MSG_WAIT, S_FINX, S_TAGX
  } state_e;

  localparam logic [3:0] RND_A = 4'(ROUNDS_A);
  localparam logic [3:0] RND_B = 4'(ROUNDS_B);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;     // where PWAIT resumes
  logic [3:0] rnd_q, rnd_d;     // round count for the pending PSTART
  logic       ad_en_q;
  ascon_op_e  msg_op;

`ifdef ASCON_SEQ_DECRYPT_EN
  logic dec_q;
  assign msg_op = dec_q ? AsconOp5 : AsconOp4;
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt_i;
  assign msg_op         = AsconOp4;
`endif

  // State register, return state, round count and mode latches
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      rnd_q   <= 4'd0;
      ad_en_q <= 1'b0;
`ifdef ASCON_SEQ_DECRYPT_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rnd_q   <= rnd_d;
      if (state_q == S_IDLE && start_i) begin
        ad_en_q <= ad_en_i;
`ifdef ASCON_SEQ_DECRYPT_EN
        dec_q   <= decrypt_i;
`endif
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      S_IDLE:   if (start_i) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_PSTART;
        ret_d   = S_KEYX;
        rnd_d   = RND_A;
      end
      // perm_done_i is not looked at here, so a done coincident with the start
      // pulse cannot short-circuit the wait.
      S_PSTART: state_d = S_PWAIT;
      S_PWAIT:  if (perm_done_i) state_d = ret_q;
      S_KEYX:   state_d = ad_en_q ? S_AD_WAIT : S_DOMSEP;
      S_AD_WAIT: if (blk_valid_i) begin
        state_d = S_PSTART;
        ret_d   = blk_last_i ? S_DOMSEP : S_AD_WAIT;
        rnd_d   = RND_B;
      end
      S_DOMSEP: state_d = S_MSG_WAIT;
      // The last message block skips its permutation: finalization follows directly.
      S_MSG_WAIT: if (blk_valid_i) begin
        if (blk_last_i) begin
          state_d = S_FINX;
        end else begin
          state_d = S_PSTART;
          ret_d   = S_MSG_WAIT;
          rnd_d   = RND_B;
        end
      end
      S_FINX: begin
        state_d = S_PSTART;
        ret_d   = S_TAGX;
        rnd_d   = RND_A;
      end
      S_TAGX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; only the op in the block-wait states depends on blk_valid_i
  always_comb begin
    blk_ready_o   = 1'b0;
    op_valid_o    = 1'b0;
    op_o          = AsconOp8;
    perm_start_o  = 1'b0;
    perm_rounds_o = 4'd0;
    busy_o        = (state_q != S_IDLE);
    done_o        = 1'b0;
    unique case (state_q)
      S_LOAD:   begin op_valid_o = 1'b1; op_o = AsconOp0; end
      S_PSTART: begin perm_start_o = 1'b1; perm_rounds_o = rnd_q; end
      S_KEYX:   begin op_valid_o = 1'b1; op_o = AsconOp1; end
      S_AD_WAIT: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin op_valid_o = 1'b1; op_o = AsconOp2; end
      end
      S_DOMSEP: begin op_valid_o = 1'b1; op_o = AsconOp3; end
      S_MSG_WAIT: begin
        blk_ready_o = 1'b1;
        if (blk_valid_i) begin op_valid_o = 1'b1; op_o = msg_op; end
      end
      S_FINX:   begin op_valid_o = 1'b1; op_o = AsconOp6; end
      S_TAGX:   begin op_valid_o = 1'b1; op_o = AsconOp7; done_o = 1'b1; end
      default: ;
    endcase
  end

endmodule
